// File: rtl/tile_cmd_writer.sv
// rtl/tile_cmd_writer.sv - LCD 8080 tile writer: CASET/PASET/RAMWR then 400 RGB565 pixels per map tile
// Optional feature macro: TILE_OUTLINE_EN (blank the one-pixel tile border for nonzero objects).
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   diff       tile-update request, sampled only in IDLE
//   x, y       tile column (0..15) and tile row (0..11); y > 11 is dropped
//   obj_code   object code mapped to an RGB565 color
//   cmd_done   one-cycle pulse when the tile has been written
//   busy       high from acceptance through the cmd_done cycle
//   csx        LCD chip select, active low
//   dcx        LCD data/command select, 0 = command
//   wr_n       LCD write strobe, active low
//   lcd_data   LCD parallel data byte
module tile_cmd_writer (
  input  logic       clk,
  input  logic       rst,
  input  logic       diff,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  output logic       cmd_done,
  output logic       busy,
  output logic       csx,
  output logic       dcx,
  output logic       wr_n,
  output logic [7:0] lcd_data
);
  localparam logic [9:0] LAST_BYTE = 10'd810;

  typedef enum logic [2:0] {IDLE, CMD, PARAM, PIXEL, DONE, HOLD} state_t;
  state_t state;

  logic [3:0] lat_x;
  logic [3:0] lat_y;
  logic [2:0] lat_obj;
  logic [9:0] byte_cnt;  // index of the byte currently on the bus
  logic       half;      // 0: strobe-low cycle, 1: strobe-high cycle
`ifdef TILE_OUTLINE_EN
  logic [4:0] pix_col;   // position of the pixel whose bytes are loaded next
  logic [4:0] pix_row;
`endif

  // 20*v as 16*v + 4*v
  logic [15:0] xs, xe, ys, ye;
  assign xs = {8'd0, lat_x, 4'd0} + {10'd0, lat_x, 2'd0};
  assign ys = {8'd0, lat_y, 4'd0} + {10'd0, lat_y, 2'd0};
  assign xe = xs + 16'd19;
  assign ye = ys + 16'd19;

  logic [15:0] map_color;
  logic [15:0] pix_color;
  always_comb begin
    case (lat_obj)
      3'd0:    map_color = 16'h0000;
      3'd1:    map_color = 16'h8410;
      3'd2:    map_color = 16'h07E0;
      3'd3:    map_color = 16'h03E0;
      3'd4:    map_color = 16'hF800;
      default: map_color = 16'hFFFF;
    endcase
  end

`ifdef TILE_OUTLINE_EN
  logic on_edge;
  assign on_edge = (pix_col == 5'd0) || (pix_col == 5'd19) ||
                   (pix_row == 5'd0) || (pix_row == 5'd19);
  // obj_code 0 already maps to black, so blanking unconditionally is equivalent
  assign pix_color = on_edge ? 16'h0000 : map_color;
`else
  assign pix_color = map_color;
`endif

  // Byte that follows the current one; index 0 (0x2A) is loaded at acceptance.
  logic [9:0] nxt_cnt;
  logic [7:0] nxt_data;
  logic       nxt_dcx;
  state_t     nxt_state;
  assign nxt_cnt = byte_cnt + 10'd1;

  always_comb begin
    nxt_data  = 8'h00;
    nxt_dcx   = 1'b1;
    nxt_state = PARAM;
    case (nxt_cnt)
      10'd1:  nxt_data = xs[15:8];
      10'd2:  nxt_data = xs[7:0];
      10'd3:  nxt_data = xe[15:8];
      10'd4:  nxt_data = xe[7:0];
      10'd5:  begin nxt_data = 8'h2B; nxt_dcx = 1'b0; nxt_state = CMD; end
      10'd6:  nxt_data = ys[15:8];
      10'd7:  nxt_data = ys[7:0];
      10'd8:  nxt_data = ye[15:8];
      10'd9:  nxt_data = ye[7:0];
      10'd10: begin nxt_data = 8'h2C; nxt_dcx = 1'b0; nxt_state = CMD; end
      default: begin
        // pixel bytes start at index 11, so odd indices carry the high byte
        nxt_state = PIXEL;
        nxt_data  = nxt_cnt[0] ? pix_color[15:8] : pix_color[7:0];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lat_x    <= 4'd0;
      lat_y    <= 4'd0;
      lat_obj  <= 3'd0;
      byte_cnt <= 10'd0;
      half     <= 1'b0;
      cmd_done <= 1'b0;
      busy     <= 1'b0;
      csx      <= 1'b1;
      dcx      <= 1'b1;
      wr_n     <= 1'b1;
      lcd_data <= 8'h00;
`ifdef TILE_OUTLINE_EN
      pix_col  <= 5'd0;
      pix_row  <= 5'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (diff) begin
            lat_x    <= x;
            lat_y    <= y;
            lat_obj  <= obj_code;
            busy     <= 1'b1;
            byte_cnt <= 10'd0;
            half     <= 1'b0;
`ifdef TILE_OUTLINE_EN
            pix_col  <= 5'd0;
            pix_row  <= 5'd0;
`endif
            if (y > 4'd11) begin
              state    <= DONE;
              cmd_done <= 1'b1;
            end else begin
              state    <= CMD;
              csx      <= 1'b0;
              dcx      <= 1'b0;
              wr_n     <= 1'b0;
              lcd_data <= 8'h2A;
            end
          end
        end
        CMD, PARAM, PIXEL: begin
          if (!half) begin
            wr_n <= 1'b1;
            half <= 1'b1;
          end else if (byte_cnt == LAST_BYTE) begin
            state    <= DONE;
            csx      <= 1'b1;
            dcx      <= 1'b1;
            lcd_data <= 8'h00;
            cmd_done <= 1'b1;
            half     <= 1'b0;
            byte_cnt <= 10'd0;
          end else begin
            byte_cnt <= nxt_cnt;
            half     <= 1'b0;
            wr_n     <= 1'b0;
            dcx      <= nxt_dcx;
            lcd_data <= nxt_data;
            state    <= nxt_state;
`ifdef TILE_OUTLINE_EN
            // low byte loaded: the pixel is complete, move to the next raster position
            if (nxt_state == PIXEL && !nxt_cnt[0]) begin
              if (pix_col == 5'd19) begin
                pix_col <= 5'd0;
                pix_row <= (pix_row == 5'd19) ? 5'd0 : pix_row + 5'd1;
              end else begin
                pix_col <= pix_col + 5'd1;
              end
            end
`endif
          end
        end
        DONE: begin
          cmd_done <= 1'b0;
          busy     <= 1'b0;
          state    <= HOLD;
        end
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_cmd_writer.sv
// tb/tb_tile_cmd_writer.sv - randomized self-checking bench for tile_cmd_writer
module tb_tile_cmd_writer;
  logic       clk = 1'b0;
  logic       rst;
  logic       diff;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       cmd_done;
  logic       busy;
  logic       csx;
  logic       dcx;
  logic       wr_n;
  logic [7:0] lcd_data;

  int n_tests = 0;
  int n_fail  = 0;

  tile_cmd_writer dut (
    .clk      (clk),
    .rst      (rst),
    .diff     (diff),
    .x        (x),
    .y        (y),
    .obj_code (obj_code),
    .cmd_done (cmd_done),
    .busy     (busy),
    .csx      (csx),
    .dcx      (dcx),
    .wr_n     (wr_n),
    .lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {dcx, data} of byte k for a tile, from the byte-stream rules.
  function automatic logic [8:0] model_byte(input int k, input int tx, input int ty, input int tobj);
    int colors[8];
    int xs, xe, ys, ye, p, color, w;
    colors = '{32'h0000, 32'h8410, 32'h07E0, 32'h03E0, 32'hF800, 32'hFFFF, 32'hFFFF, 32'hFFFF};
    xs = 20 * tx; xe = xs + 19; ys = 20 * ty; ye = ys + 19;
    case (k)
      0:  return {1'b0, 8'h2A};
      5:  return {1'b0, 8'h2B};
      10: return {1'b0, 8'h2C};
      1, 2, 3, 4, 6, 7, 8, 9: begin
        int param[10];
        param = '{0, xs / 256, xs % 256, xe / 256, xe % 256, 0, ys / 256, ys % 256, ye / 256, ye % 256};
        w = param[k];
        return {1'b1, 8'(w)};
      end
      default: begin
        p = (k - 11) / 2;
        color = colors[tobj];
`ifdef TILE_OUTLINE_EN
        if (tobj != 0 && (p % 20 == 0 || p % 20 == 19 || p / 20 == 0 || p / 20 == 19))
          color = 0;
`endif
        w = ((k - 11) % 2 == 0) ? color / 256 : color % 256;
        return {1'b1, 8'(w)};
      end
    endcase
  endfunction

  // Called with the DUT in IDLE; the next rising edge is the acceptance edge (cycle 0).
  task automatic run_tile(input int tx, input int ty, input int tobj, input bit keep, input int next_x);
    bit valid;
    int last;
    logic [8:0] eb;
    logic [3:0] ectl;
    valid = (ty <= 11);
    last  = valid ? 1624 : 2;
    x = 4'(tx); y = 4'(ty); obj_code = 3'(tobj); diff = 1'b1;
    @(posedge clk); #1;
    if (!keep) begin
      diff = 1'b0;
      x = 4'($urandom); y = 4'($urandom); obj_code = 3'($urandom);
    end
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (valid) begin
        ectl = {c <= 1623, c == 1623, !(c <= 1622), !((c % 2 == 1) && c <= 1621)};
        check_eq($sformatf("ctl x%0d y%0d c%0d", tx, ty, c), 32'({busy, cmd_done, csx, wr_n}), 32'(ectl));
        if (c <= 1622) begin
          eb = model_byte((c - 1) / 2, tx, ty, tobj);
          check_eq($sformatf("byte%0d x%0d y%0d c%0d", (c - 1) / 2, tx, ty, c),
                   32'({dcx, lcd_data}), 32'(eb));
        end
      end else begin
        ectl = (c == 1) ? 4'b1111 : 4'b0011;
        check_eq($sformatf("oor y%0d c%0d", ty, c), 32'({busy, cmd_done, csx, wr_n}), 32'(ectl));
      end
      if (keep && c == 100) x = 4'(next_x);
    end
  endtask

  // Step out of HOLD and confirm one quiet IDLE cycle.
  task automatic settle_idle(input string tag);
    @(posedge clk);
    @(negedge clk);
    check_eq(tag, 32'({busy, cmd_done, csx, wr_n}), 32'(4'b0011));
  endtask

  initial begin
    rst = 1'b1; diff = 1'b0; x = 4'd0; y = 4'd0; obj_code = 3'd0;
    repeat (2) @(negedge clk);
    check_eq("reset_outputs", 32'({csx, dcx, wr_n, lcd_data, cmd_done, busy}),
             32'({1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0}));
    rst = 1'b0;

    run_tile(0, 0, 4, 1'b0, 0);
    settle_idle("idle_after_origin");
    run_tile(15, 11, 2, 1'b0, 0);
    settle_idle("idle_after_corner");
    run_tile(0, 12, 3, 1'b0, 0);
    settle_idle("idle_after_oor12");
    run_tile(7, 15, 1, 1'b0, 0);
    settle_idle("idle_after_oor15");

    // back-to-back with diff held high, x moved to 4 mid-transaction
    run_tile(3, 5, 1, 1'b1, 4);
    settle_idle("idle_between_b2b");
    run_tile(4, 5, 1, 1'b0, 0);
    settle_idle("idle_after_b2b");

`ifdef TILE_OUTLINE_EN
    run_tile(2, 2, 1, 1'b0, 0);
    settle_idle("idle_after_outline");
`endif

    // abort mid-PIXEL
    x = 4'd5; y = 4'd3; obj_code = 3'd2; diff = 1'b1;
    @(posedge clk); #1;
    diff = 1'b0;
    repeat (600) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_abort_outputs", 32'({csx, dcx, wr_n, lcd_data, cmd_done, busy}),
             32'({1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0}));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("rst_hold%0d", i), 32'({cmd_done, busy, csx, wr_n}), 32'(4'b0011));
    end
    rst = 1'b0;
    run_tile(9, 4, 3, 1'b0, 0);
    settle_idle("idle_after_rst_restart");

    for (int i = 0; i < 6; i++) begin
      int rx, ry, ro;
      rx = int'($urandom_range(0, 15));
      ry = int'($urandom_range(0, 13));
      ro = int'($urandom_range(0, 7));
      run_tile(rx, ry, ro, 1'b0, 0);
      settle_idle($sformatf("idle_after_rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_cmd_writer.md
TILE_CMD_WRITER -- requirements
Module: tile_cmd_writer

Interface
REQ-001: The module SHALL have port clk, input, 1 bit: system clock, rising-edge active.
REQ-002: The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003: The module SHALL have port diff, input, 1 bit: tile-update request from the map scanner.
REQ-004: The module SHALL have ports x (input, 4 bits) and y (input, 4 bits): tile column 0..15 and tile row 0..11.
REQ-005: The module SHALL have port obj_code, input, 3 bits: object in the tile.
REQ-006: The module SHALL have port cmd_done, output, 1 bit: single-cycle pulse when the tile has been written.
REQ-007: The module SHALL have port busy, output, 1 bit: high from request acceptance through the cmd_done cycle.
REQ-008: The module SHALL have ports csx, dcx and wr_n, outputs, 1 bit each: LCD 8080 chip-select (active low), data/command select (0 = command) and write strobe (active low).
REQ-009: The module SHALL have port lcd_data, output, 8 bits: LCD parallel data byte.

Function
REQ-010: The FSM SHALL have the states IDLE, CMD, PARAM, PIXEL, DONE and HOLD.
REQ-011: In IDLE, diff=1 SHALL latch x, y and obj_code; the acceptance cycle is cycle 0.
REQ-012: A request with y>11 SHALL produce no bus writes, and cmd_done SHALL pulse in cycle 1.
REQ-013: A valid request SHALL emit 811 bytes, in this order:
- 0x2A, then XS[15:8], XS[7:0], XE[15:8], XE[7:0];
- 0x2B, then YS[15:8], YS[7:0], YE[15:8], YE[7:0];
- 0x2C;
- 400 pixels as 800 bytes, color high byte first.
REQ-014: Tile bounds SHALL be XS=20*x, XE=XS+19, YS=20*y and YE=YS+19, all computed in 16-bit unsigned arithmetic.
REQ-015: Byte k (0..810) SHALL drive wr_n low in cycle 2k+1 and high in cycle 2k+2, with lcd_data and dcx stable across both cycles.
REQ-016: dcx SHALL be 0 only for the bytes 0x2A, 0x2B and 0x2C.
REQ-017: csx SHALL be 0 from cycle 1 through cycle 1622 and 1 otherwise.
REQ-018: cmd_done SHALL pulse high for exactly cycle 1623 (the DONE state).
REQ-019: The pixel color SHALL be RGB565 selected by obj_code as follows:
- 0 = 0x0000 (empty);
- 1 = 0x8410 (border);
- 2 = 0x07E0 (body);
- 3 = 0x03E0 (head);
- 4 = 0xF800 (apple);
- 5..7 = 0xFFFF.
REQ-020: diff SHALL be ignored while busy=1 and during HOLD.
REQ-021: HOLD SHALL last exactly one cycle after DONE, then the FSM SHALL return to IDLE.
REQ-022: A diff held continuously high SHALL start the next transaction on the first IDLE cycle.
REQ-023: Changes on x, y or obj_code after acceptance SHALL have no effect on the transaction in progress.

Reset
REQ-024: While rst=1, the outputs SHALL be csx=1, dcx=1, wr_n=1, lcd_data=0x00, cmd_done=0 and busy=0, the FSM SHALL be in IDLE, and all counters SHALL be 0.
REQ-025: Assertion of rst mid-transaction SHALL abort the transaction immediately, with no cmd_done pulse.
REQ-026: After rst is released, the first rising clk edge SHALL sample diff from IDLE.

Configuration
REQ-027: When the macro TILE_OUTLINE_EN is defined, pixels in tile row 0, row 19, column 0 or column 19 SHALL be sent as 0x0000 for nonzero obj_code, and interior pixels SHALL use the mapped color.
REQ-028: When TILE_OUTLINE_EN is undefined, all 400 pixels SHALL use the mapped color, and the row/column pixel counters SHALL NOT be generated.
REQ-029: Byte count and timing SHALL be identical with and without TILE_OUTLINE_EN.

Verification
REQ-030: Reset scenario: assert rst mid-PIXEL, then release it -> idle output values as in REQ-024 with no cmd_done; a new diff then starts at byte 0x2A.
REQ-031: Tile-origin scenario: x=0, y=0, obj_code=4 -> bytes 2A 00 00 00 13 2B 00 00 00 13 2C followed by 400 pairs F8 00; cmd_done in cycle 1623 only.
REQ-032: Far-corner scenario: x=15, y=11, obj_code=2 -> CASET parameters 01 2C 01 3F, PASET parameters 00 DC 00 EF, and pixel pairs 07 E0.
REQ-033: Out-of-range scenario: y=12 -> no wr_n low pulse, csx stays 1, and cmd_done=1 in cycle 1.
REQ-034: Back-to-back scenario: diff held high, with x changed from 3 to 4 at cycle 100 -> the first transaction uses XS=60, the second starts at cycle 1625 with XS=80, and exactly one cmd_done pulse occurs per transaction.
REQ-035: Outline scenario, with TILE_OUTLINE_EN defined: obj_code=1 -> pixels 0..19 are 00 00, pixel 21 is 84 10, and pixel 39 is 00 00.
